// File: rtl/universal_shift_register_n_pkg.sv
// Shared encodings for the universal shift register: mode opcodes,
// burst FSM states and burst direction constants.
package shift_reg_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_SHR  = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_LOAD = 3'b011,
        MODE_ROR  = 3'b100,
        MODE_ROL  = 3'b101,
        MODE_ASR  = 3'b110,
        MODE_RSVD = 3'b111
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/universal_shift_register_n_if.sv
// Bus bundle for the universal shift register: control, data and status.
interface universal_shift_register_n_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
);
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] din;
    logic             rightshift;
    logic             leftshift;
    logic             start;
    logic             burst_dir;
    logic [CNT_W-1:0] burst_len;
    logic [WIDTH-1:0] q;
    logic             sout_right;
    logic             sout_left;
    logic             busy;
    logic             done;

    modport master (
        output en, mode, din, rightshift, leftshift, start, burst_dir, burst_len,
        input  q, sout_right, sout_left, busy, done
    );

    modport slave (
        input  en, mode, din, rightshift, leftshift, start, burst_dir, burst_len,
        output q, sout_right, sout_left, busy, done
    );
endinterface

// File: rtl/universal_shift_register_n_next_state.sv
// Combinational next-q selector shared by mode operations and burst shifts.
module usr_next_state
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  mode_e            op,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] din,
    input  logic             rightshift,
    input  logic             leftshift,
    output logic [WIDTH-1:0] q_next
);
    always_comb begin
        q_next = q;
        case (op)
            MODE_SHR:  q_next = {rightshift, q[WIDTH-1:1]};
            MODE_SHL:  q_next = {q[WIDTH-2:0], leftshift};
            MODE_LOAD: q_next = din;
            MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
            MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
            default:   q_next = q;
        endcase
    end
endmodule

// File: rtl/universal_shift_register_n.sv
// N-bit universal shift register with rotate/arithmetic modes and an
// autonomous burst-shift engine (start/busy/done).
module universal_shift_register_n
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic clk,
    input logic sync_reset,
    universal_shift_register_n_if.slave bus
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] q_q, q_d;
    mode_e            op;

    usr_next_state #(.WIDTH(WIDTH)) u_next (
        .op         (op),
        .q          (q_q),
        .din        (bus.din),
        .rightshift (bus.rightshift),
        .leftshift  (bus.leftshift),
        .q_next     (q_d)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        op      = MODE_HOLD;
        case (state_q)
            ST_SHIFT: begin
                // Burst owns the register: en/mode/din/start are ignored here.
                op     = (dir_q == DIR_LEFT) ? MODE_SHL : MODE_SHR;
                cnt_d  = cnt_q - CNT_W'(1);
                busy_d = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                if (bus.start) begin
                    // q holds in the accepting cycle; start beats en/mode.
                    dir_d = bus.burst_dir;
                    cnt_d = bus.burst_len;
                    if (bus.burst_len != '0) begin
                        state_d = ST_SHIFT;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                    if (bus.en) op = mode_e'(bus.mode);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dir_q   <= DIR_RIGHT;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            q_q     <= q_d;
        end
    end

    assign bus.q          = q_q;
    assign bus.sout_right = q_q[0];
    assign bus.sout_left  = q_q[WIDTH-1];
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule
